// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM states, grant
// encoding, stall vectors and wait-counter width.
package bus_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF  = 1'b0,
      GNT_MEM = 1'b1
   } grant_e;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester, memory-bus and stall signals of the arbiter. The slave modport
// is the arbiter's view; master is the environment driving it.
interface bus_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        bus_ce;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdata;

   logic [5:0]  stall_o;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_rdata,
      output if_rdata, if_ack, mem_rdata, mem_ack,
      output bus_ce, bus_we, bus_addr, bus_wdata, bus_sel, stall_o
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_rdata,
      input  if_rdata, if_ack, mem_rdata, mem_ack,
      input  bus_ce, bus_we, bus_addr, bus_wdata, bus_sel, stall_o
   );

endinterface

// File: rtl/arb_grant.sv
// Grant decision between instruction and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on conflicts using the last grant; otherwise data wins.
module arb_grant
   import bus_arbiter_pkg::*;
(
   input  logic   if_req,
   input  logic   mem_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  grant_e last_grant,
`endif
   output grant_e grant
);

   always_comb begin
      grant = GNT_MEM;
`ifdef ARB_ROUND_ROBIN_EN
      if (mem_req && if_req)
         grant = (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
      else if (mem_req)
         grant = GNT_MEM;
      else if (if_req)
         grant = GNT_IF;
`else
      if (mem_req)
         grant = GNT_MEM;
      else if (if_req)
         grant = GNT_IF;
`endif
   end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one single-port memory between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating grants on conflicts (default: data priority).
//
//   state | meaning
//   IDLE  | waiting for a request; latch winner and its operands
//   BUSY  | bus_ce high, counting down WAIT_CYCLES; capture read data on last cycle
//   DONE  | one-cycle ack pulse to the granted side
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
)(
   input  logic clk,
   input  logic rst,
   bus_arbiter_if.slave bif
);

   state_e            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   grant_e            grant_q,     grant_d;
   logic              bus_ce_q,    bus_ce_d;
   logic              bus_we_q,    bus_we_d;
   logic [31:0]       bus_addr_q,  bus_addr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [3:0]        bus_sel_q,   bus_sel_d;
   logic              if_ack_q,    if_ack_d;
   logic              mem_ack_q,   mem_ack_d;
   logic [31:0]       if_rdata_q,  if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   grant_e            new_grant;
   logic              mem_pend, if_pend;
   logic [5:0]        stall;

`ifdef ARB_ROUND_ROBIN_EN
   grant_e            last_grant_q, last_grant_d;
`endif

   arb_grant u_arb_grant (
      .if_req     (bif.if_req),
      .mem_req    (bif.mem_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant_q),
`endif
      .grant      (new_grant)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      bus_ce_d    = bus_ce_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_sel_d   = bus_sel_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (bif.if_req || bif.mem_req) begin
               state_d  = BUSY;
               cnt_d    = CNT_W'(WAIT_CYCLES);
               grant_d  = new_grant;
               bus_ce_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = new_grant;
`endif
               if (new_grant == GNT_MEM) begin
                  bus_we_d    = bif.mem_we;
                  bus_addr_d  = bif.mem_addr;
                  bus_wdata_d = bif.mem_wdata;
                  bus_sel_d   = bif.mem_sel;
               end else begin
                  bus_we_d    = 1'b0;
                  bus_addr_d  = bif.if_addr;
                  bus_wdata_d = '0;
                  bus_sel_d   = 4'hF;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d  = DONE;
               bus_ce_d = 1'b0;
               bus_we_d = 1'b0;
               if (grant_q == GNT_MEM) begin
                  mem_ack_d = 1'b1;
                  // writes leave the data-side read register untouched
                  if (!bus_we_q)
                     mem_rdata_d = bif.bus_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bif.bus_rdata;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= GNT_MEM;
         bus_ce_q    <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_sel_q   <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= GNT_IF;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         bus_ce_q    <= bus_ce_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_sel_q   <= bus_sel_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // an in-flight transfer stays pending even if its requester dropped req early
   always_comb begin
      mem_pend = bif.mem_req || (state_q == BUSY && grant_q == GNT_MEM);
      if_pend  = bif.if_req  || (state_q == BUSY && grant_q == GNT_IF);
      stall    = STALL_NONE;
      if (rst)
         stall = STALL_NONE;
      else if (mem_pend && !mem_ack_q)
         stall = STALL_MEM;
      else if (if_pend && !if_ack_q)
         stall = STALL_IF;
   end

   assign bif.bus_ce    = bus_ce_q;
   assign bif.bus_we    = bus_we_q;
   assign bif.bus_addr  = bus_addr_q;
   assign bif.bus_wdata = bus_wdata_q;
   assign bif.bus_sel   = bus_sel_q;
   assign bif.if_ack    = if_ack_q;
   assign bif.mem_ack   = mem_ack_q;
   assign bif.if_rdata  = if_rdata_q;
   assign bif.mem_rdata = mem_rdata_q;
   assign bif.stall_o   = stall;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with WAIT_CYCLES=1, one with 3.
module tb_bus_arbiter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   bus_arbiter_if a ();
   bus_arbiter_if b ();

   bus_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bif(a));
   bus_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bif(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bus_we must never be high while the bus is idle
   always @(negedge clk) begin
      if (!rst) begin
         if (!a.bus_ce) chk("we_idle_a", {31'd0, a.bus_we}, 32'd0);
         if (!b.bus_ce) chk("we_idle_b", {31'd0, b.bus_we}, 32'd0);
      end
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      a.if_req = 0; a.if_addr = 0; a.mem_req = 0; a.mem_we = 0;
      a.mem_addr = 0; a.mem_wdata = 0; a.mem_sel = 0; a.bus_rdata = 0;
      b.if_req = 0; b.if_addr = 0; b.mem_req = 0; b.mem_we = 0;
      b.mem_addr = 0; b.mem_wdata = 0; b.mem_sel = 0; b.bus_rdata = 0;
      tick();
      tick();

      // reset state
      chk("rst_bus_ce",   {31'd0, a.bus_ce},  32'd0);
      chk("rst_bus_addr", a.bus_addr,         32'd0);
      chk("rst_bus_sel",  {28'd0, a.bus_sel}, 32'd0);
      chk("rst_acks",     {30'd0, a.if_ack, a.mem_ack}, 32'd0);
      chk("rst_rdata",    a.if_rdata | a.mem_rdata, 32'd0);
      chk("rst_stall",    {26'd0, a.stall_o}, 32'd0);
      chk("rst_b_ce",     {31'd0, b.bus_ce},  32'd0);

      rst = 1'b0;
      tick();

      // single fetch, WAIT_CYCLES=1
      a.if_req = 1; a.if_addr = 32'h100; a.bus_rdata = 32'h3C010001;
      #1;
      chk("f_stall_n",   {26'd0, a.stall_o}, 32'h03);
      tick();
      chk("f_ce_n1",     {31'd0, a.bus_ce},  32'd1);
      chk("f_addr_n1",   a.bus_addr,         32'h100);
      chk("f_stall_n1",  {26'd0, a.stall_o}, 32'h03);
      chk("f_ack_n1",    {31'd0, a.if_ack},  32'd0);
      tick();
      chk("f_ack_n2",    {31'd0, a.if_ack},  32'd1);
      chk("f_ce_n2",     {31'd0, a.bus_ce},  32'd0);
      chk("f_rdata_n2",  a.if_rdata,         32'h3C010001);
      chk("f_stall_n2",  {26'd0, a.stall_o}, 32'h00);
      a.if_req = 0;
      a.bus_rdata = 32'hFFFF0000;
      tick();
      chk("f_ack_n3",    {31'd0, a.if_ack},  32'd0);
      chk("f_hold_n3",   a.if_rdata,         32'h3C010001);

      // simultaneous write + fetch: data side first
      a.mem_req = 1; a.mem_we = 1; a.mem_addr = 32'h200;
      a.mem_wdata = 32'hDEADBEEF; a.mem_sel = 4'hF;
      a.if_req = 1; a.if_addr = 32'h104; a.bus_rdata = 32'hAAAA5555;
      #1;
      chk("c_stall_n",   {26'd0, a.stall_o}, 32'h1F);
      tick();
      chk("c_ce_n1",     {31'd0, a.bus_ce},  32'd1);
      chk("c_we_n1",     {31'd0, a.bus_we},  32'd1);
      chk("c_addr_n1",   a.bus_addr,         32'h200);
      chk("c_wdata_n1",  a.bus_wdata,        32'hDEADBEEF);
      chk("c_sel_n1",    {28'd0, a.bus_sel}, 32'hF);
      chk("c_stall_n1",  {26'd0, a.stall_o}, 32'h1F);
      tick();
      chk("c_mack_n2",   {31'd0, a.mem_ack}, 32'd1);
      chk("c_iack_n2",   {31'd0, a.if_ack},  32'd0);
      chk("c_mrd_n2",    a.mem_rdata,        32'd0);
      chk("c_stall_n2",  {26'd0, a.stall_o}, 32'h03);
      a.mem_req = 0; a.mem_we = 0;
      tick();
      chk("c_ce_n3",     {31'd0, a.bus_ce},  32'd0);
      chk("c_stall_n3",  {26'd0, a.stall_o}, 32'h03);
      tick();
      chk("c_ce_n4",     {31'd0, a.bus_ce},  32'd1);
      chk("c_addr_n4",   a.bus_addr,         32'h104);
      tick();
      chk("c_iack_n5",   {31'd0, a.if_ack},  32'd1);
      chk("c_ird_n5",    a.if_rdata,         32'hAAAA5555);
      chk("c_mack_n5",   {31'd0, a.mem_ack}, 32'd0);
      a.if_req = 0;
      tick();

      // data read, WAIT_CYCLES=3
      b.mem_req = 1; b.mem_we = 0; b.mem_addr = 32'h300; b.mem_sel = 4'hF;
      b.bus_rdata = 32'h12345678;
      tick();
      chk("w3_ce_n1",    {31'd0, b.bus_ce},  32'd1);
      tick();
      chk("w3_ce_n2",    {31'd0, b.bus_ce},  32'd1);
      tick();
      chk("w3_ce_n3",    {31'd0, b.bus_ce},  32'd1);
      chk("w3_ack_n3",   {31'd0, b.mem_ack}, 32'd0);
      tick();
      chk("w3_ack_n4",   {31'd0, b.mem_ack}, 32'd1);
      chk("w3_ce_n4",    {31'd0, b.bus_ce},  32'd0);
      chk("w3_rd_n4",    b.mem_rdata,        32'h12345678);
      b.mem_req = 0;
      tick();
      chk("w3_ack_n5",   {31'd0, b.mem_ack}, 32'd0);

      // early-dropped fetch still completes
      b.if_req = 1; b.if_addr = 32'h180; b.bus_rdata = 32'h0000BEEF;
      tick();
      b.if_req = 0;
      #1;
      chk("ed_stall",    {26'd0, b.stall_o}, 32'h03);
      tick();
      tick();
      chk("ed_ack_n3",   {31'd0, b.if_ack},  32'd0);
      tick();
      chk("ed_ack_n4",   {31'd0, b.if_ack},  32'd1);
      chk("ed_rd_n4",    b.if_rdata,         32'h0000BEEF);
      tick();

      // reset during BUSY aborts the access
      a.mem_req = 1; a.mem_we = 0; a.mem_addr = 32'h500; a.bus_rdata = 32'h55555555;
      tick();
      chk("r_ce_busy",   {31'd0, a.bus_ce},  32'd1);
      rst = 1'b1;
      a.mem_req = 0;
      tick();
      chk("r_ce",        {31'd0, a.bus_ce},  32'd0);
      chk("r_mack",      {31'd0, a.mem_ack}, 32'd0);
      chk("r_ird",       a.if_rdata,         32'd0);
      chk("r_addr",      a.bus_addr,         32'd0);
      chk("r_stall",     {26'd0, a.stall_o}, 32'd0);
      tick();
      chk("r_mack2",     {31'd0, a.mem_ack}, 32'd0);
      rst = 1'b0;
      a.if_req = 1; a.if_addr = 32'h108; a.bus_rdata = 32'h0BADF00D;
      tick();
      chk("r_new_ce",    {31'd0, a.bus_ce},  32'd1);
      chk("r_new_addr",  a.bus_addr,         32'h108);
      tick();
      chk("r_new_ack",   {31'd0, a.if_ack},  32'd1);
      chk("r_new_rd",    a.if_rdata,         32'h0BADF00D);
      a.if_req = 0;
      tick();

      // both requests held: grant sequence on repeated conflicts
      a.mem_req = 1; a.mem_we = 0; a.mem_addr = 32'h400;
      a.if_req = 1; a.if_addr = 32'h10C;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
         exp_addr = (k % 2 == 0) ? 32'h400 : 32'h10C;
`else
         exp_addr = 32'h400;
`endif
         tick();
         chk($sformatf("rr_addr_%0d", k), a.bus_addr, exp_addr);
         tick();
         chk($sformatf("rr_mack_%0d", k), {31'd0, a.mem_ack},
             (exp_addr == 32'h400) ? 32'd1 : 32'd0);
         chk($sformatf("rr_iack_%0d", k), {31'd0, a.if_ack},
             (exp_addr == 32'h400) ? 32'd0 : 32'd1);
         tick();
      end
      a.mem_req = 0; a.if_req = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving the memory access cycles per transfer (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have instruction-side ports if_req in 1 (fetch request), if_addr in 32, if_rdata out 32, if_ack out 1 (one-cycle completion pulse).
REQ-005 SHALL have data-side ports mem_req in 1, mem_we in 1, mem_addr in 32, mem_wdata in 32, mem_sel in 4 (byte enables), mem_rdata out 32, mem_ack out 1.
REQ-006 SHALL have memory-side ports bus_ce out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_sel out 4, bus_rdata in 32.
REQ-007 SHALL have port stall_o  out  6  pipeline stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.

Function
REQ-008 SHALL arbitrate one single-port memory between the instruction and data requesters using FSM states IDLE, BUSY, DONE.
REQ-009 In IDLE with any request present, SHALL latch the grant plus that requester's addr/we/wdata/sel, load wait counter with WAIT_CYCLES, and go to BUSY.
REQ-010 On simultaneous requests in IDLE (default build), SHALL grant the data side.
REQ-011 In BUSY, SHALL drive bus_ce=1 and the latched request onto the bus_* outputs, and decrement the counter each cycle.
REQ-012 On the last BUSY cycle (counter=1), SHALL register bus_rdata into the granted side's rdata output and go to DONE.
REQ-013 In DONE, SHALL pulse the granted side's ack for exactly one cycle with bus_ce=0, then return to IDLE.
REQ-014 Latency: request first seen in IDLE at cycle N gives bus_ce high for cycles N+1..N+WAIT_CYCLES and ack at cycle N+WAIT_CYCLES+1.
REQ-015 For writes (mem_we=1), SHALL leave mem_rdata unchanged and still pulse mem_ack.
REQ-016 if_rdata/mem_rdata SHALL hold their value until the next completed read for that side.
REQ-017 Requesters hold req and operands until ack; an early-dropped request SHALL still complete with its ack pulse.
REQ-018 In the ack cycle, SHALL NOT count the acked requester as pending; it may re-request from the following IDLE cycle.
REQ-019 stall_o: mem_req pending and not acked gives 6'b011111; else if_req pending and not acked gives 6'b000011; else 6'b000000. The data-side value has priority.
REQ-020 bus_we SHALL be 0 whenever bus_ce=0.

Reset
REQ-021 While rst=1, SHALL force state IDLE, counter 0, grant to data side, bus_ce=0, bus_we=0, bus_addr/bus_wdata=0, bus_sel=0, if_ack=mem_ack=0, if_rdata=mem_rdata=0, stall_o=0.
REQ-022 Reset mid-access SHALL abort the transfer with no ack issued, and SHALL accept a new request in the first cycle after rst falls.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the side not granted last (last-grant flag reset to instruction, so the first conflict goes to data).
REQ-024 Macro ARB_ROUND_ROBIN_EN undefined: fixed data-over-instruction priority per REQ-010, and no last-grant register is instantiated.

Structure
REQ-025 The shared defines package SHALL hold the FSM state encodings, the stall vector constants (STALL_NONE, STALL_IF, STALL_MEM), and the counter width.
REQ-026 The grant decision SHALL sit in one sub-module, arb_grant, which takes both requests and the last grant and returns the grant.

Verification
REQ-027 WAIT_CYCLES=1, if_req only, if_addr=0x100, bus_rdata=0x3C010001: bus_ce high cycle N+1, if_ack at N+2, if_rdata=0x3C010001, stall_o=000011 until ack.
REQ-028 Both requests at N, mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF, mem_sel=4'hF: data access first with bus_we=1, mem_ack at N+2, then the fetch, if_ack at N+5; stall_o=011111 during the data access.
REQ-029 WAIT_CYCLES=3, mem read, bus_rdata=0x12345678: bus_ce high 3 cycles, mem_ack at N+4, mem_rdata=0x12345678.
REQ-030 rst asserted during BUSY: no ack; all outputs zero next cycle; a request after rst falls completes normally.
REQ-031 ARB_ROUND_ROBIN_EN defined, both requests held continuously: grants alternate data, instr, data, instr; in the default build, data wins every conflict.
